// File: rtl/exu_wb_arbiter.sv
// Integer regfile write-port arbiter. The ALU wins by default, MULDIV and load share the port
// round-robin, and per-requester starvation counters force a one-cycle ALU stall.
module exu_wb_arbiter #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned LREG_W       = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_wb_valid_i,
  input  logic [LREG_W-1:0] alu_wb_rd_i,
  input  logic [XLEN-1:0]   alu_wb_data_i,
  output logic              alu_stall_o,
  input  logic              md_wb_valid_i,
  input  logic [LREG_W-1:0] md_wb_rd_i,
  input  logic [XLEN-1:0]   md_wb_data_i,
  output logic              md_wb_ready_o,
  input  logic              ld_wb_valid_i,
  input  logic [LREG_W-1:0] ld_wb_rd_i,
  input  logic [XLEN-1:0]   ld_wb_data_i,
  output logic              ld_wb_ready_o,
  output logic              wb_valid_o,
  output logic [LREG_W-1:0] wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic              rr_q, rr_d;
  logic [3:0]        md_cnt_q, md_cnt_d;
  logic [3:0]        ld_cnt_q, ld_cnt_d;
  logic              wb_valid_q, wb_valid_d;
  logic [LREG_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  logic md_starved, ld_starved;
  logic gnt_alu, gnt_md, gnt_ld;

  assign md_starved = (md_cnt_q == Limit);
  assign ld_starved = (ld_cnt_q == Limit);

  always_comb begin
    gnt_alu = 1'b0;
    gnt_md  = 1'b0;
    gnt_ld  = 1'b0;
    if (alu_wb_valid_i) begin
      gnt_alu = 1'b1;
    end else if (md_wb_valid_i && !ld_wb_valid_i) begin
      gnt_md = 1'b1;
    end else if (ld_wb_valid_i && !md_wb_valid_i) begin
      gnt_ld = 1'b1;
    end else if (md_wb_valid_i && ld_wb_valid_i) begin
      if (md_starved && !ld_starved) begin
        gnt_md = 1'b1;
      end else if (ld_starved && !md_starved) begin
        gnt_ld = 1'b1;
      end else if (rr_q) begin
        gnt_ld = 1'b1;
      end else begin
        gnt_md = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_md) begin
      rr_d = 1'b1;
    end else if (gnt_ld) begin
      rr_d = 1'b0;
    end

    md_cnt_d = 4'd0;
    if (md_wb_valid_i && !gnt_md) begin
      md_cnt_d = md_starved ? md_cnt_q : md_cnt_q + 4'd1;
    end
    ld_cnt_d = 4'd0;
    if (ld_wb_valid_i && !gnt_ld) begin
      ld_cnt_d = ld_starved ? ld_cnt_q : ld_cnt_q + 4'd1;
    end

    // A grant to x0 still updates wb_rd/wb_data but never raises the write enable.
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (gnt_alu) begin
      wb_valid_d = (alu_wb_rd_i != '0);
      wb_rd_d    = alu_wb_rd_i;
      wb_data_d  = alu_wb_data_i;
    end else if (gnt_md) begin
      wb_valid_d = (md_wb_rd_i != '0);
      wb_rd_d    = md_wb_rd_i;
      wb_data_d  = md_wb_data_i;
    end else if (gnt_ld) begin
      wb_valid_d = (ld_wb_rd_i != '0);
      wb_rd_d    = ld_wb_rd_i;
      wb_data_d  = ld_wb_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= 1'b0;
      md_cnt_q   <= 4'd0;
      ld_cnt_q   <= 4'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      rr_q       <= rr_d;
      md_cnt_q   <= md_cnt_d;
      ld_cnt_q   <= ld_cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign alu_stall_o   = md_starved | ld_starved;
  assign md_wb_ready_o = gnt_md;
  assign ld_wb_ready_o = gnt_ld;
  assign wb_valid_o    = wb_valid_q;
  assign wb_rd_o       = wb_rd_q;
  assign wb_data_o     = wb_data_q;

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Directed bench for exu_wb_arbiter: reset, ALU path, round-robin, starvation and reset recovery.
module tb_exu_wb_arbiter;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned LREG_W = 5;

  logic              clk;
  logic              rst;
  logic              alu_v;
  logic [LREG_W-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_stall;
  logic              md_v;
  logic [LREG_W-1:0] md_rd;
  logic [XLEN-1:0]   md_data;
  logic              md_rdy;
  logic              ld_v;
  logic [LREG_W-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic              ld_rdy;
  logic              wb_v;
  logic [LREG_W-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  int n_cmp = 0;
  int n_err = 0;

  exu_wb_arbiter #(
    .XLEN        (XLEN),
    .LREG_W      (LREG_W),
    .STARVE_LIMIT(4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .alu_wb_valid_i(alu_v),
    .alu_wb_rd_i   (alu_rd),
    .alu_wb_data_i (alu_data),
    .alu_stall_o   (alu_stall),
    .md_wb_valid_i (md_v),
    .md_wb_rd_i    (md_rd),
    .md_wb_data_i  (md_data),
    .md_wb_ready_o (md_rdy),
    .ld_wb_valid_i (ld_v),
    .ld_wb_rd_i    (ld_rd),
    .ld_wb_data_i  (ld_data),
    .ld_wb_ready_o (ld_rdy),
    .wb_valid_o    (wb_v),
    .wb_rd_o       (wb_rd),
    .wb_data_o     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit past the next rising edge; inputs are changed only here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_v = 1'b0; alu_rd = '0; alu_data = '0;
    md_v  = 1'b0; md_rd  = '0; md_data  = '0;
    ld_v  = 1'b0; ld_rd  = '0; ld_data  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({wb_v, wb_rd, wb_data} !== '0) begin
      n_err++;
      $display("FAIL reset_wb: got v=%0b rd=%0d data=%0h, want 0/0/0", wb_v, wb_rd, wb_data);
    end
    n_cmp++;
    if ({alu_stall, md_rdy, ld_rdy} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctl: got stall/md_rdy/ld_rdy=%03b, want 000",
               {alu_stall, md_rdy, ld_rdy});
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({wb_v, alu_stall} !== 2'b00) begin
        n_err++;
        $display("FAIL idle_%0d: got wb_valid/alu_stall=%02b, want 00", i, {wb_v, alu_stall});
      end
    end
  endtask

  task automatic test_alu();
    do_reset();
    alu_v = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    tick();
    n_cmp++;
    if ({wb_v, wb_rd, wb_data} !== {1'b1, 5'd5, 64'h1234}) begin
      n_err++;
      $display("FAIL alu_write: got v=%0b rd=%0d data=%0h, want 1/5/1234", wb_v, wb_rd, wb_data);
    end
    alu_rd = 5'd0; alu_data = 64'hABCD;
    tick();
    n_cmp++;
    if ({wb_v, wb_rd, wb_data} !== {1'b0, 5'd0, 64'hABCD}) begin
      n_err++;
      $display("FAIL alu_x0: got v=%0b rd=%0d data=%0h, want 0/0/abcd", wb_v, wb_rd, wb_data);
    end
    alu_v = 1'b0; alu_rd = 5'd9; alu_data = 64'h5555;
    tick();
    n_cmp++;
    if ({wb_v, wb_rd, wb_data} !== {1'b0, 5'd0, 64'hABCD}) begin
      n_err++;
      $display("FAIL alu_hold: got v=%0b rd=%0d data=%0h, want 0/0/abcd", wb_v, wb_rd, wb_data);
    end
  endtask

  task automatic test_round_robin();
    logic [LREG_W-1:0] exp_rd;
    do_reset();
    md_v = 1'b1; md_rd = 5'd3; md_data = 64'h33;
    ld_v = 1'b1; ld_rd = 5'd7; ld_data = 64'h77;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_rd = (i % 2 == 0) ? 5'd3 : 5'd7;
      n_cmp++;
      if ({md_rdy, ld_rdy} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL rr_ready_%0d: got md/ld=%02b, want %02b", i, {md_rdy, ld_rdy},
                 (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick();
      n_cmp++;
      if ({wb_v, wb_rd} !== {1'b1, exp_rd}) begin
        n_err++;
        $display("FAIL rr_wb_%0d: got v=%0b rd=%0d, want 1/%0d", i, wb_v, wb_rd, exp_rd);
      end
    end
    clear_inputs();
  endtask

  task automatic test_x0_slow();
    do_reset();
    md_v = 1'b1; md_rd = 5'd0; md_data = 64'hDEAD;
    #1;
    n_cmp++;
    if (md_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL md_x0_ready: got %0b, want 1", md_rdy);
    end
    tick();
    n_cmp++;
    if ({wb_v, wb_data} !== {1'b0, 64'hDEAD}) begin
      n_err++;
      $display("FAIL md_x0_wb: got v=%0b data=%0h, want 0/dead", wb_v, wb_data);
    end
    // x0 grant still advances rr_q, so load is preferred next.
    md_rd = 5'd4; ld_v = 1'b1; ld_rd = 5'd8;
    #1;
    n_cmp++;
    if ({md_rdy, ld_rdy} !== 2'b01) begin
      n_err++;
      $display("FAIL x0_rr: got md/ld=%02b, want 01", {md_rdy, ld_rdy});
    end
    clear_inputs();
  endtask

  task automatic test_starvation();
    do_reset();
    alu_v = 1'b1; alu_rd = 5'd1; alu_data = 64'h1;
    md_v  = 1'b1; md_rd  = 5'd9; md_data  = 64'h99;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({alu_stall, md_rdy} !== 2'b00) begin
        n_err++;
        $display("FAIL starve_wait_%0d: got stall/md_rdy=%02b, want 00", i, {alu_stall, md_rdy});
      end
      tick();
    end
    n_cmp++;
    if (alu_stall !== 1'b1) begin
      n_err++;
      $display("FAIL starve_stall: got %0b, want 1", alu_stall);
    end
    alu_v = 1'b0;
    #1;
    n_cmp++;
    if (md_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL starve_grant: got %0b, want 1", md_rdy);
    end
    tick();
    md_v = 1'b0;
    n_cmp++;
    if ({alu_stall, wb_v, wb_rd, wb_data} !== {1'b0, 1'b1, 5'd9, 64'h99}) begin
      n_err++;
      $display("FAIL starve_release: got stall=%0b v=%0b rd=%0d data=%0h, want 0/1/9/99",
               alu_stall, wb_v, wb_rd, wb_data);
    end
  endtask

  task automatic test_stall_violation();
    do_reset();
    alu_v = 1'b1; alu_rd = 5'd2; alu_data = 64'h2;
    md_v  = 1'b1; md_rd  = 5'd6; md_data  = 64'h66;
    repeat (4) tick();
    alu_rd = 5'd12; alu_data = 64'hC0FFEE;
    #1;
    n_cmp++;
    if ({alu_stall, md_rdy} !== 2'b10) begin
      n_err++;
      $display("FAIL viol_ctl: got stall/md_rdy=%02b, want 10", {alu_stall, md_rdy});
    end
    tick();
    n_cmp++;
    if ({alu_stall, wb_v, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd12, 64'hC0FFEE}) begin
      n_err++;
      $display("FAIL viol_wb: got stall=%0b v=%0b rd=%0d data=%0h, want 1/1/12/c0ffee",
               alu_stall, wb_v, wb_rd, wb_data);
    end
    alu_v = 1'b0;
    #1;
    n_cmp++;
    if (md_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL viol_recover: got md_rdy=%0b, want 1", md_rdy);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_both_starved();
    do_reset();
    alu_v = 1'b1; alu_rd = 5'd1; alu_data = 64'h1;
    md_v  = 1'b1; md_rd  = 5'd10; md_data = 64'hA0;
    ld_v  = 1'b1; ld_rd  = 5'd11; ld_data = 64'hB0;
    repeat (4) tick();
    alu_v = 1'b0;
    #1;
    n_cmp++;
    if ({alu_stall, md_rdy, ld_rdy} !== 3'b110) begin
      n_err++;
      $display("FAIL both_first: got stall/md/ld=%03b, want 110", {alu_stall, md_rdy, ld_rdy});
    end
    tick();
    n_cmp++;
    if ({alu_stall, md_rdy, ld_rdy, wb_rd} !== {3'b101, 5'd10}) begin
      n_err++;
      $display("FAIL both_second: got stall/md/ld=%03b rd=%0d, want 101/10",
               {alu_stall, md_rdy, ld_rdy}, wb_rd);
    end
    tick();
    n_cmp++;
    if ({alu_stall, wb_v, wb_rd} !== {1'b0, 1'b1, 5'd11}) begin
      n_err++;
      $display("FAIL both_release: got stall=%0b v=%0b rd=%0d, want 0/1/11", alu_stall, wb_v,
               wb_rd);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    alu_v = 1'b1; alu_rd = 5'd1; alu_data = 64'h1;
    md_v  = 1'b1; md_rd  = 5'd13; md_data = 64'hD0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({alu_stall, wb_v} !== 2'b00) begin
      n_err++;
      $display("FAIL midrst_clear: got stall/wb_valid=%02b, want 00", {alu_stall, wb_v});
    end
    repeat (3) tick();
    n_cmp++;
    if (alu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_count: got stall=%0b, want 0", alu_stall);
    end
    alu_v = 1'b0;
    #1;
    n_cmp++;
    if (md_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_grant: got md_rdy=%0b, want 1", md_rdy);
    end
    tick();
    clear_inputs();
    n_cmp++;
    if ({wb_v, wb_rd} !== {1'b1, 5'd13}) begin
      n_err++;
      $display("FAIL midrst_wb: got v=%0b rd=%0d, want 1/13", wb_v, wb_rd);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_alu();
    test_round_robin();
    test_x0_slow();
    test_starvation();
    test_stall_violation();
    test_both_starved();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exu_wb_arbiter.md
# exu_wb_arbiter

Shares the single integer register-file write port between the three execution-result sources: single-cycle ALU/BJU, multi-cycle MULDIV and load return. The ALU path never backpressures and normally has top priority. MULDIV and load compete round-robin under valid/ready. A saturating starvation counter per slow requester forces a one-cycle ALU stall so that no requester waits more than STARVE_LIMIT cycles. It sits between the exu results and the regfile write port. Its registered output also feeds the exu operand-forwarding path.

## Interface
- XLEN, 64, data width of results and of the write port
- LREG_W, 5, logical register index width
- STARVE_LIMIT, 4, consecutive denied cycles before a requester is promoted; legal range 1..15
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alu_wb_valid  in  1  ALU/BJU result present this cycle; no ready, always accepted
- alu_wb_rd  in  LREG_W  destination register
- alu_wb_data  in  XLEN  result
- alu_stall  out  1  request to hold the ALU instruction next cycle; derived from registers only
- md_wb_valid / md_wb_rd / md_wb_data  in  1 / LREG_W / XLEN  MULDIV result request
- md_wb_ready  out  1  MULDIV result accepted this cycle
- ld_wb_valid / ld_wb_rd / ld_wb_data  in  1 / LREG_W / XLEN  load result request
- ld_wb_ready  out  1  load result accepted this cycle
- wb_valid  out  1  regfile write enable, registered
- wb_rd  out  LREG_W  regfile write index, registered
- wb_data  out  XLEN  regfile write data, registered

## Operation
- State: rr_q (1 bit, 0 = MULDIV preferred, 1 = load preferred), md_cnt_q and ld_cnt_q (4 bits each, saturating at STARVE_LIMIT), output registers.
- Starved flags: md_starved = (md_cnt_q == STARVE_LIMIT). ld_starved is defined the same way.
- alu_stall = md_starved | ld_starved.
- Grant, evaluated combinationally each cycle:
  - alu_wb_valid=1 → grant ALU.
  - Otherwise, only one of MULDIV/load valid → grant it.
  - Otherwise, both valid and exactly one starved → grant the starved one.
  - Otherwise, both valid → grant per rr_q.
- md_wb_ready = grant MULDIV. ld_wb_ready = grant load. A valid request must hold its rd/data stable until ready.
- rr_q update: after a MULDIV grant, rr_q←1. After a load grant, rr_q←0. Otherwise rr_q is unchanged.
- Counter update for each slow requester:
  - valid & not granted → increment, saturating at STARVE_LIMIT.
  - granted or not valid → clear to 0.
- ALU contract: while alu_stall=1 the exu must present alu_wb_valid=0.
  - If alu_wb_valid=1 anyway, the ALU still wins, so no result is lost. The counters stay saturated and alu_stall stays high.
- Writes to x0: a grant with rd==0 still asserts the requester's ready and counts as a grant for rr_q and the counters. wb_valid stays 0 for that write.
- Output registers: wb_valid←granted & (rd≠0). wb_rd/wb_data load the granted source's rd/data whenever a grant occurs and hold otherwise.

## Timing
- Reset (synchronous, reset=1 at an edge): wb_valid=0, wb_rd=0, wb_data=0, rr_q=0, both counters 0.
  - As a result, alu_stall=0. md_wb_ready and ld_wb_ready follow the grant logic; they are 0 while no slow requester is valid.
- Reset asserted mid-request: all state clears. A requester still holding valid is re-arbitrated from rr_q=0 on the first cycle after reset.
- Latency: a result granted in cycle N appears on wb_* in cycle N+1. There is exactly one write per cycle at most.
- ready is combinational from same-cycle valids and registered state. There is no combinational path from any input to alu_stall.
- Worst-case wait for a continuously valid slow requester:
  - Against a continuous ALU stream: STARVE_LIMIT denied cycles, then alu_stall rises, then it is granted in the next cycle that ALU honours the stall.
  - Against the other slow requester only: at most 1 denied cycle (round-robin).
- Simultaneous starvation of both: the ALU stalls, one slow requester is granted per rr_q, and the other is granted the following cycle. alu_stall stays high until both counters clear.

## Test plan
- Reset then idle: hold reset 2 cycles → all outputs 0. Release with no valids → wb_valid=0, alu_stall=0 for 10 cycles.
- ALU alone: alu_wb_valid=1, rd=5, data=0x1234 at cycle N → wb_valid=1, wb_rd=5, wb_data=0x1234 at N+1.
  - Same with rd=0 → wb_valid=0.
- Round-robin: md and ld both valid continuously (md rd=3, ld rd=7) with no ALU → grants alternate MULDIV, load, MULDIV, …, starting with MULDIV after reset. wb_rd sequence is 3,7,3,7.
- Starvation (STARVE_LIMIT=4): ALU valid every cycle, md valid from cycle 0 → md_cnt reaches 4 at cycle 4 and alu_stall=1 at cycle 4.
  - The bench drops alu_wb_valid → md_wb_ready=1 in cycle 4, then alu_stall=0 at cycle 5.
- Stall violation: alu_stall=1 and alu_wb_valid forced 1 → ALU written, md_wb_ready=0, alu_stall remains 1.
- Reset mid-wait: md valid and md_cnt=3 when reset is pulsed → md_cnt=0, alu_stall=0. md is granted on the first idle-ALU cycle.
